wide_add_seq: RTL
=================

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter WORDS, default 4, meaning the number of 32-bit words per operand (operand width = 32*WORDS, WORDS >= 2).
REQ-002 SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  32*WORDS  operand A.
REQ-008 b  input  32*WORDS  operand B.
REQ-009 cin  input  1  carry-in to word 0.
REQ-010 sub  input  1  subtract request, honoured only per REQ-028.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 sum  output  32*WORDS  result.
REQ-014 cout  output  1  carry out of the top word.
REQ-015 ovf  output  1  two's-complement overflow of the full-width result.

Function
REQ-016 SHALL share one 32-bit ripple adder across all words, processing one word per clock, least-significant word first.
REQ-017 FSM states SHALL be IDLE, RUN and DONE.
- IDLE->RUN on in_valid && in_ready.
- RUN->DONE after word WORDS-1.
- DONE->IDLE on out_valid && out_ready.
REQ-018 in_ready SHALL be 1 only in IDLE and SHALL be decoded from state.
REQ-019 On acceptance, SHALL register a, b and effective carry-in, set word index 0, and clear the sum register.
REQ-020 Each RUN cycle SHALL:
- add a-word[idx], effective b-word[idx] and the carry register;
- write sum word idx;
- load the carry register from the adder carry-out;
- increment idx.
REQ-021 Latency: out_valid SHALL rise exactly WORDS clock edges after the accepting edge.
REQ-022 cout SHALL equal the final carry register value.
REQ-023 ovf SHALL be 1 when the registered A and effective-B MSBs are equal and the sum MSB differs from them; ovf SHALL be valid with out_valid.
REQ-024 In DONE, sum, cout and ovf SHALL hold stable while out_ready=0; in_valid SHALL be ignored.
REQ-025 New operands SHALL NOT be accepted in the same cycle as the output handshake; acceptance is possible from the following cycle.
REQ-026 Operand inputs changing during RUN or DONE SHALL NOT affect the result.

Reset
REQ-027 On rst:
- state=IDLE, idx=0, carry register=0;
- sum=0, cout=0, ovf=0, out_valid=0, in_ready=1 once rst deasserts.
- rst during RUN or DONE SHALL discard the operation with no out_valid pulse.

Configuration
REQ-028 Macro WIDE_ADD_SUB_EN:
- Defined: when sub=1 at acceptance, effective B = ~b, effective carry-in = 1, cin ignored.
- Undefined: sub is ignored, effective B = b, effective carry-in = cin.
- The port list SHALL be identical in both builds.

Structure
REQ-029 Package wide_add_pkg SHALL hold:
- constant WORD_W = 32;
- the FSM state enum typedef (IDLE, RUN, DONE);
- the index-width function clog2(WORDS).
REQ-030 The adder SHALL be the existing fulladder32 sub-module, instantiated once: A and B fed from the selected words, Pin from the carry register, S to the sum word, Pout to the carry-register input.

Verification (WORDS=4)
REQ-031 a=all-ones(128), b=1, cin=0 -> sum=0, cout=1, ovf=0, out_valid exactly 4 edges after acceptance.
REQ-032 a=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, b=1 -> sum=0x...0001_0000_0000 (word1=1, word0=0), cout=0.
REQ-033 a=0x7FFF...FFFF, b=1 -> sum=0x8000...0000, ovf=1, cout=0.
REQ-034 Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a -> sum/cout stable, in_ready=0, no second acceptance; out_ready=1 -> IDLE on the next edge.
REQ-035 rst asserted 2 edges into RUN -> out_valid stays 0, sum=0; after release in_ready=1 and a new add completes correctly.
REQ-036 WIDE_ADD_SUB_EN defined, sub=1, a=5, b=7 -> sum=0xFFFF...FFFE, cout=0, ovf=0; same stimulus without the macro -> sum=12.

Source files
------------

// File: rtl/wide_add_pkg.sv
// rtl/wide_add_pkg.sv - shared constants, FSM state type and index-width helper for wide_add_seq
package wide_add_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to index n words (n >= 2 gives at least 1 bit).
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >>> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fulladder32.sv
// rtl/fulladder32.sv - 32-bit ripple-carry adder with carry in (Pin) and carry out (Pout)
module fulladder32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Pin,
  output logic [31:0] S,
  output logic        Pout
);

  logic [32:0] c;

  // Ripple the carry bit by bit from Pin up to Pout.
  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = Pin;
    for (int i = 0; i < 32; i++) begin
      S[i]     = A[i] ^ B[i] ^ c[i];
      c[i + 1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
    end
    Pout = c[32];
  end

endmodule

// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - word-serial wide adder sharing one 32-bit adder; WIDE_ADD_SUB_EN enables subtract
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W*WORDS-1:0]   a,
  input  logic [WORD_W*WORDS-1:0]   b,
  input  logic                      cin,
  input  logic                      sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W*WORDS-1:0]   sum,
  output logic                      cout,
  output logic                      ovf
);

  localparam int IW = clog2(WORDS);

  state_t                        state;
  logic [IW-1:0]                 idx;
  logic [WORDS-1:0][WORD_W-1:0]  a_r;
  logic [WORDS-1:0][WORD_W-1:0]  b_r;
  logic [WORDS-1:0][WORD_W-1:0]  sum_r;
  logic                          carry;
  logic                          cout_r;
  logic                          ovf_r;
  logic                          out_valid_r;

  logic [WORD_W*WORDS-1:0]       b_eff;
  logic                          c_eff;
  logic [WORD_W-1:0]             s_word;
  logic                          pout;
  logic                          is_last;
  logic                          a_msb;
  logic                          b_msb;

`ifdef WIDE_ADD_SUB_EN
  // Subtract is a + ~b + 1; cin is overridden when sub is requested.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign c_eff      = cin;
`endif

  assign is_last = (idx == IW'(WORDS - 1));
  assign a_msb   = a_r[WORDS-1][WORD_W-1];
  assign b_msb   = b_r[WORDS-1][WORD_W-1];

  fulladder32 u_add (
    .A    (a_r[idx]),
    .B    (b_r[idx]),
    .Pin  (carry),
    .S    (s_word),
    .Pout (pout)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

  // Control FSM plus datapath: capture operands, add one word per RUN cycle, hold result in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= b_eff;
            carry  <= c_eff;
            idx    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_r[idx] <= s_word;
          carry      <= pout;
          if (is_last) begin
            idx         <= '0;
            cout_r      <= pout;
            ovf_r       <= (a_msb == b_msb) && (s_word[WORD_W-1] != a_msb);
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
